// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared encodings for the multicycle MIPS controller: FSM state
//             codes, opcode/funct constants, ALUOp and alu_ctrl encodings,
//             plus a helper that identifies the states in which an
//             instruction completes.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

   // Controller states. Codes 12-15 are not used.
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALUOp: what the main controller asks the ALU decoder for
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // alu_ctrl: operation code presented to the ALU
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // PCSrc encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

   // True for the final state of every instruction; leaving one of these
   // states means an instruction has completed.
   function automatic logic is_retire_state(input state_t s);
      case (s)
         S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
            is_retire_state = 1'b1;
         default:
            is_retire_state = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Combinational translation of ALUOp (+ funct for R-type) into
//             the 3-bit ALU operation code.
//  Ports    : alu_op   in  [1:0]  operation class from the main controller
//             funct    in  [5:0]  IR[5:0]
//             alu_ctrl out [2:0]  ALU operation code
//  Revision : 1.0  initial release
// ============================================================================
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               // unsupported funct falls back to add
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         // ALUOp 11 is never issued; treat it as add
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Moore FSM controller for the multicycle MIPS datapath with a
//             sticky illegal-opcode flag and a retired-instruction counter.
//  Ports    : clk, rst_n (sync, active-low)
//             opcode[5:0], funct[5:0], zero            -- from IR / ALU
//             MemRead, MemWrite, IorD                   -- memory control
//             IRWrite, pc_en, PCSrc[1:0]                -- IR / PC control
//             ALUSrcA, ALUSrcB[1:0], alu_ctrl[2:0]      -- ALU control
//             RegDst, MemtoReg, RegWrite                -- register file
//             illegal_op, state[3:0], instr_retired     -- status / debug
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             pc_en,
   output logic [1:0]       PCSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       alu_ctrl,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_retired
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic             r_illegal;
   logic [CNT_W-1:0] r_count;

   // raw per-state controls, before reset gating
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_iord;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_branch;
   logic [1:0] w_pc_src;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic       w_reg_dst;
   logic       w_mem_to_reg;
   logic       w_reg_write;
   logic       w_state_valid;
   logic       w_illegal_seen;
   logic       w_retire;
   logic [2:0] w_alu_ctrl;

   // ------------------------------------------------------------------
   // State, flag and counter registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state <= w_next;
         if (w_illegal_seen) begin
            r_illegal <= 1'b1;
         end
         if (w_retire) begin
            r_count <= r_count + CNT_ONE;
         end
      end
   end

   assign w_retire = is_retire_state(r_state);

   // ------------------------------------------------------------------
   // Next-state and Moore outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_next         = S_FETCH;
      w_mem_read     = 1'b0;
      w_mem_write    = 1'b0;
      w_iord         = 1'b0;
      w_ir_write     = 1'b0;
      w_pc_write     = 1'b0;
      w_branch       = 1'b0;
      w_pc_src       = PCSRC_ALU;
      w_alu_src_a    = 1'b0;
      w_alu_src_b    = SRCB_REG;
      w_alu_op       = ALUOP_ADD;
      w_reg_dst      = 1'b0;
      w_mem_to_reg   = 1'b0;
      w_reg_write    = 1'b0;
      w_state_valid  = 1'b1;
      w_illegal_seen = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_ir_write  = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            w_pc_write  = 1'b1;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            // branch target computed speculatively while decoding
            w_alu_src_b = SRCB_IMMSL2;
            case (opcode)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXEC;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default: begin
                  w_next         = S_FETCH;
                  w_illegal_seen = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
            // only lw/sw reach here, so anything but sw is a load
            w_next      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
            w_next     = S_MEMWB;
         end
         S_MEMWB: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
            w_next      = S_FETCH;
         end
         S_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALUOP_FUNCT;
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALUOP_SUB;
            w_pc_src    = PCSRC_ALUOUT;
            w_branch    = 1'b1;
            w_next      = S_FETCH;
         end
         S_ADDIEX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
            w_next      = S_ADDIWB;
         end
         S_ADDIWB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_JUMP: begin
            w_pc_src   = PCSRC_JUMP;
            w_pc_write = 1'b1;
            w_next     = S_FETCH;
         end
         default: begin
            // unused codes: recover to FETCH with every output low
            w_state_valid = 1'b0;
            w_next        = S_FETCH;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op   (w_alu_op),
      .funct    (funct),
      .alu_ctrl (w_alu_ctrl)
   );

   // ------------------------------------------------------------------
   // Outputs. Everything is held low while rst_n is asserted so that no
   // memory, PC or register-file side effect can happen during reset.
   // ------------------------------------------------------------------
   assign MemRead       = rst_n & w_mem_read;
   assign MemWrite      = rst_n & w_mem_write;
   assign IorD          = rst_n & w_iord;
   assign IRWrite       = rst_n & w_ir_write;
   // the only Mealy path: zero matters only when Branch is asserted
   assign pc_en         = rst_n & (w_pc_write | (w_branch & zero));
   assign PCSrc         = rst_n ? w_pc_src    : 2'b00;
   assign ALUSrcA       = rst_n & w_alu_src_a;
   assign ALUSrcB       = rst_n ? w_alu_src_b : 2'b00;
   assign alu_ctrl      = (rst_n && w_state_valid) ? w_alu_ctrl : 3'b000;
   assign RegDst        = rst_n & w_reg_dst;
   assign MemtoReg      = rst_n & w_mem_to_reg;
   assign RegWrite      = rst_n & w_reg_write;
   assign illegal_op    = rst_n & r_illegal;
   assign state         = rst_n ? r_state     : 4'd0;
   assign instr_retired = rst_n ? r_count     : '0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Directed self-checking bench for multicycle_control. Each step
//             drives the inputs for one cycle, queues the expected state,
//             control vector, retire count and illegal flag, then compares
//             them against the DUT mid-cycle (negative edge).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        MemRead, MemWrite, IorD, IRWrite, pc_en;
   logic [1:0]  PCSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [2:0]  alu_ctrl;
   logic        RegDst, MemtoReg, RegWrite;
   logic        illegal_op;
   logic [3:0]  state;
   logic [31:0] instr_retired;

   multicycle_control #(.CNT_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .funct         (funct),
      .zero          (zero),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .IorD          (IorD),
      .IRWrite       (IRWrite),
      .pc_en         (pc_en),
      .PCSrc         (PCSrc),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .alu_ctrl      (alu_ctrl),
      .RegDst        (RegDst),
      .MemtoReg      (MemtoReg),
      .RegWrite      (RegWrite),
      .illegal_op    (illegal_op),
      .state         (state),
      .instr_retired (instr_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {MemRead, MemWrite, IorD, IRWrite, pc_en, PCSrc, ALUSrcA, ALUSrcB,
   //  alu_ctrl, RegDst, MemtoReg, RegWrite}
   logic [16:0] obs_vec;
   assign obs_vec = {MemRead, MemWrite, IorD, IRWrite, pc_en, PCSrc, ALUSrcA,
                     ALUSrcB, alu_ctrl, RegDst, MemtoReg, RegWrite};

   localparam logic [16:0] V_ZERO   = 17'd0;
   localparam logic [16:0] V_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_MEMRD  = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b0,1'b1,1'b1};
   localparam logic [16:0] V_MEMWR  = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b1,1'b0,1'b1};
   localparam logic [16:0] V_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0};
   localparam logic [16:0] V_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b010,1'b0,1'b0,1'b1};
   localparam logic [16:0] V_JUMP   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b010,1'b0,1'b0,1'b0};

   function automatic logic [16:0] v_exec(input logic [2:0] a);
      v_exec = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,a,1'b0,1'b0,1'b0};
   endfunction

   function automatic logic [16:0] v_branch(input logic z);
      v_branch = {1'b0,1'b0,1'b0,1'b0,z,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0};
   endfunction

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] vec;
      logic [31:0] ret;
      logic        ill;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_ret = 32'd0;
   logic        exp_ill = 1'b0;

   task automatic check_out();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (state === e.st) else begin
         n_fail++;
         $error("FAIL %s.state observed=%0d expected=%0d", t, state, e.st);
      end
      n_cmp++;
      assert (obs_vec === e.vec) else begin
         n_fail++;
         $error("FAIL %s.ctrl observed=%b expected=%b", t, obs_vec, e.vec);
      end
      n_cmp++;
      assert (instr_retired === e.ret) else begin
         n_fail++;
         $error("FAIL %s.retired observed=%0d expected=%0d", t, instr_retired, e.ret);
      end
      n_cmp++;
      assert (illegal_op === e.ill) else begin
         n_fail++;
         $error("FAIL %s.illegal observed=%b expected=%b", t, illegal_op, e.ill);
      end
   endtask

   // One cycle with reset released.
   task automatic step(input string tag, input logic [3:0] es, input logic [16:0] ev);
      rst_n = 1'b1;
      exp_q.push_back('{st: es, vec: ev, ret: exp_ret, ill: exp_ill});
      tag_q.push_back(tag);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   // One cycle with reset asserted: every output must read zero.
   task automatic rstep(input string tag);
      rst_n = 1'b0;
      exp_q.push_back('{st: 4'd0, vec: V_ZERO, ret: 32'd0, ill: 1'b0});
      tag_q.push_back(tag);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
      opcode = op;
      funct  = fn;
      zero   = z;
   endtask

   logic [5:0] fn_tab [4];
   logic [2:0] alu_tab[4];

   initial begin
      fn_tab[0] = 6'b100010; alu_tab[0] = 3'b110;
      fn_tab[1] = 6'b100100; alu_tab[1] = 3'b000;
      fn_tab[2] = 6'b100101; alu_tab[2] = 3'b001;
      fn_tab[3] = 6'b111111; alu_tab[3] = 3'b010;

      rst_n = 1'b0;
      set_in(6'b000000, 6'b101010, 1'b0);
      rstep("reset0");
      rstep("reset1");

      // slt
      set_in(6'b000000, 6'b101010, 1'b0);
      step("slt_fetch",  4'd0, V_FETCH);
      step("slt_decode", 4'd1, V_DECODE);
      step("slt_exec",   4'd6, v_exec(3'b111));
      step("slt_aluwb",  4'd7, V_ALUWB);
      exp_ret++;

      // sw
      set_in(6'b101011, 6'b000000, 1'b0);
      step("sw_fetch",  4'd0, V_FETCH);
      step("sw_decode", 4'd1, V_DECODE);
      step("sw_memadr", 4'd2, V_MEMADR);
      step("sw_memwr",  4'd5, V_MEMWR);
      exp_ret++;

      // lw
      set_in(6'b100011, 6'b000000, 1'b0);
      step("lw_fetch",  4'd0, V_FETCH);
      step("lw_decode", 4'd1, V_DECODE);
      step("lw_memadr", 4'd2, V_MEMADR);
      step("lw_memrd",  4'd3, V_MEMRD);
      step("lw_memwb",  4'd4, V_MEMWB);
      exp_ret++;

      // beq taken: zero high in DECODE must not move the PC
      set_in(6'b000100, 6'b000000, 1'b1);
      step("beqt_fetch",  4'd0, V_FETCH);
      step("beqt_decode", 4'd1, V_DECODE);
      step("beqt_branch", 4'd8, v_branch(1'b1));
      exp_ret++;

      // beq not taken
      set_in(6'b000100, 6'b000000, 1'b0);
      step("beqn_fetch",  4'd0, V_FETCH);
      step("beqn_decode", 4'd1, V_DECODE);
      step("beqn_branch", 4'd8, v_branch(1'b0));
      exp_ret++;

      // addi
      set_in(6'b001000, 6'b000000, 1'b0);
      step("addi_fetch",  4'd0, V_FETCH);
      step("addi_decode", 4'd1, V_DECODE);
      step("addi_ex",     4'd9, V_ADDIEX);
      step("addi_wb",     4'd10, V_ADDIWB);
      exp_ret++;

      // j
      set_in(6'b000010, 6'b000000, 1'b0);
      step("j_fetch",  4'd0, V_FETCH);
      step("j_decode", 4'd1, V_DECODE);
      step("j_jump",   4'd11, V_JUMP);
      exp_ret++;

      // remaining funct decodes, including an unsupported funct
      for (int i = 0; i < 4; i++) begin
         set_in(6'b000000, fn_tab[i], 1'b0);
         step($sformatf("rt%0d_fetch", i),  4'd0, V_FETCH);
         step($sformatf("rt%0d_decode", i), 4'd1, V_DECODE);
         step($sformatf("rt%0d_exec", i),   4'd6, v_exec(alu_tab[i]));
         step($sformatf("rt%0d_aluwb", i),  4'd7, V_ALUWB);
         exp_ret++;
      end

      // illegal opcode: back to FETCH, flag set, no retire
      set_in(6'b111111, 6'b000000, 1'b0);
      step("ill_fetch",  4'd0, V_FETCH);
      step("ill_decode", 4'd1, V_DECODE);
      exp_ill = 1'b1;
      // flag stays set across a following legal add
      set_in(6'b000000, 6'b100000, 1'b0);
      step("add_fetch",  4'd0, V_FETCH);
      step("add_decode", 4'd1, V_DECODE);
      step("add_exec",   4'd6, v_exec(3'b010));
      step("add_aluwb",  4'd7, V_ALUWB);
      exp_ret++;

      // reset asserted during MEMRD of a load
      set_in(6'b100011, 6'b000000, 1'b0);
      step("lwr_fetch",  4'd0, V_FETCH);
      step("lwr_decode", 4'd1, V_DECODE);
      step("lwr_memadr", 4'd2, V_MEMADR);
      rstep("lwr_reset");
      exp_ret = 32'd0;
      exp_ill = 1'b0;

      // normal slt after release
      set_in(6'b000000, 6'b101010, 1'b0);
      step("slt2_fetch",  4'd0, V_FETCH);
      step("slt2_decode", 4'd1, V_DECODE);
      step("slt2_exec",   4'd6, v_exec(3'b111));
      step("slt2_aluwb",  4'd7, V_ALUWB);
      exp_ret++;
      step("slt2_done",   4'd0, V_FETCH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
